// File: rtl/video_pattern_source_pkg.sv
// Shared types and constants for the synthetic AXI4-Stream video source:
// resolution defaults, pattern and state encodings, colour-bar palette.
package video_axis_pkg;

  localparam int unsigned DEF_H_RES = 1920;
  localparam int unsigned DEF_V_RES = 1080;
  localparam int unsigned DEF_BAR_W = 240;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_RAMP    = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_CHECKER = 2'd3
  } pattern_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } vps_state_e;

  localparam logic [31:0] COLOR_WHITE   = 32'h00FF_FFFF;
  localparam logic [31:0] COLOR_YELLOW  = 32'h00FF_FF00;
  localparam logic [31:0] COLOR_CYAN    = 32'h0000_FFFF;
  localparam logic [31:0] COLOR_GREEN   = 32'h0000_FF00;
  localparam logic [31:0] COLOR_MAGENTA = 32'h00FF_00FF;
  localparam logic [31:0] COLOR_RED     = 32'h00FF_0000;
  localparam logic [31:0] COLOR_BLUE    = 32'h0000_00FF;
  localparam logic [31:0] COLOR_BLACK   = 32'h0000_0000;

  // Per-frame configuration, captured only when a frame starts.
  typedef struct packed {
    pattern_mode_e mode;
    logic [31:0]   solid;
    logic [15:0]   h_blank;
    logic [15:0]   v_blank;
  } frame_cfg_t;

  function automatic logic [31:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOR_WHITE;
      3'd1:    return COLOR_YELLOW;
      3'd2:    return COLOR_CYAN;
      3'd3:    return COLOR_GREEN;
      3'd4:    return COLOR_MAGENTA;
      3'd5:    return COLOR_RED;
      3'd6:    return COLOR_BLUE;
      default: return COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_source_if.sv
// AXI4-Stream video bus: the pattern source drives it as master.
interface video_pattern_source_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/video_pattern_source_pattern_pixel_gen.sv
// Combinational pixel generator: maps a beat's (x, y) plus frame config to
// a 0x00RRGGBB value for the four test patterns.
module pattern_pixel_gen
  import video_axis_pkg::*;
(
  input  pattern_mode_e mode,
  input  logic [31:0]   solid_color,
  input  logic [15:0]   x,
  input  logic [15:0]   y,
  input  logic [2:0]    bar_idx,
  input  logic          frame_parity,
  output logic [31:0]   pixel
);

  logic unused_coord_bits;
  assign unused_coord_bits = ^{x[15:11], x[2:0], y[15:6], y[4:0]};

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path infers a latch.
    pixel = COLOR_BLACK;
    case (mode)
      MODE_SOLID:   pixel = solid_color;
      MODE_RAMP:    pixel = {8'h00, x[10:3], x[10:3], x[10:3]};
      MODE_BARS:    pixel = bar_color(bar_idx);
      MODE_CHECKER: pixel = (x[5] ^ y[5] ^ frame_parity) ? COLOR_WHITE : COLOR_BLACK;
      default:      pixel = COLOR_BLACK;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// Synthetic frame generator on AXI4-Stream: tuser flags the first pixel of a
// frame, tlast the last pixel of a line, with programmable H/V blanking.
module video_pattern_source
  import video_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned H_RES      = DEF_H_RES,
  parameter int unsigned V_RES      = DEF_V_RES,
  parameter int unsigned BAR_W      = DEF_BAR_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [1:0]             pattern_mode,
  input  logic [31:0]            solid_color,
  input  logic [15:0]            h_blank_cycles,
  input  logic [15:0]            v_blank_cycles,
  video_pattern_source_if.master m_axis,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam logic [15:0] X_LAST   = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_RES - 1);
  localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);

  vps_state_e            state_q, state_d;
  frame_cfg_t            cfg_q, cfg_d, cfg_in, cfg_sel;
  logic [15:0]           x_q, x_d, y_q, y_d;
  logic [15:0]           bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic [15:0]           blank_cnt_q, blank_cnt_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                  busy_q, busy_d;

  logic        accept, line_end, frame_end, start_frame, line_start, load;
  logic [15:0] gen_x, gen_y, gen_bar_cnt;
  logic [2:0]  gen_bar_idx;
  logic        gen_parity;
  logic [31:0] pixel;

  // Pixel for the beat about to be loaded into the output register.
  pattern_pixel_gen u_pixel_gen (
    .mode        (cfg_sel.mode),
    .solid_color (cfg_sel.solid),
    .x           (gen_x),
    .y           (gen_y),
    .bar_idx     (gen_bar_idx),
    .frame_parity(gen_parity),
    .pixel       (pixel)
  );

  always_comb begin
    cfg_in    = '{mode: pattern_mode_e'(pattern_mode), solid: solid_color,
                  h_blank: h_blank_cycles, v_blank: v_blank_cycles};
    accept    = tvalid_q && m_axis.tready;
    line_end  = (x_q == X_LAST);
    frame_end = line_end && (y_q == Y_LAST);

    start_frame = 1'b0;
    line_start  = 1'b0;
    case (state_q)
      ST_IDLE:   start_frame = enable;
      ST_ACTIVE: if (accept && line_end) begin
        if (frame_end) start_frame = enable && (cfg_q.v_blank == 16'd0);
        else           line_start  = (cfg_q.h_blank == 16'd0);
      end
      ST_HBLANK: line_start  = (blank_cnt_q == 16'd0);
      ST_VBLANK: start_frame = enable && (blank_cnt_q == 16'd0);
      default:   ;
    endcase

    // Config is only ever taken from the inputs at a frame start.
    cfg_sel    = start_frame ? cfg_in : cfg_q;
    gen_parity = frame_count_q[0] ^ (accept && frame_end);

    if (start_frame) begin
      gen_x       = '0;
      gen_y       = '0;
      gen_bar_cnt = '0;
      gen_bar_idx = '0;
    end else if (line_start) begin
      gen_x       = '0;
      gen_y       = (state_q == ST_ACTIVE) ? y_q + 16'd1 : y_q;
      gen_bar_cnt = '0;
      gen_bar_idx = '0;
    end else begin
      gen_x = x_q + 16'd1;
      gen_y = y_q;
      if (bar_cnt_q == BAR_LAST) begin
        gen_bar_cnt = '0;
        gen_bar_idx = bar_idx_q + 3'd1;
      end else begin
        gen_bar_cnt = bar_cnt_q + 16'd1;
        gen_bar_idx = bar_idx_q;
      end
    end

    load = start_frame || line_start || ((state_q == ST_ACTIVE) && accept && !line_end);

    state_d       = state_q;
    cfg_d         = cfg_q;
    x_d           = x_q;
    y_d           = y_q;
    bar_cnt_d     = bar_cnt_q;
    bar_idx_d     = bar_idx_q;
    blank_cnt_d   = blank_cnt_q;
    frame_count_d = frame_count_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;

    if ((state_q == ST_ACTIVE) && accept && frame_end) frame_count_d = frame_count_q + 16'd1;

    if (load) begin
      state_d   = ST_ACTIVE;
      cfg_d     = cfg_sel;
      x_d       = gen_x;
      y_d       = gen_y;
      bar_cnt_d = gen_bar_cnt;
      bar_idx_d = gen_bar_idx;
      tvalid_d  = 1'b1;
      tdata_d   = DATA_WIDTH'(pixel);
      tlast_d   = (gen_x == X_LAST);
      tuser_d   = (gen_x == 16'd0) && (gen_y == 16'd0);
    end else begin
      case (state_q)
        ST_ACTIVE: if (accept) begin
          // Only a line end with blanking or a stopping frame reaches here.
          tvalid_d = 1'b0;
          tdata_d  = '0;
          tlast_d  = 1'b0;
          tuser_d  = 1'b0;
          if (!frame_end) begin
            state_d     = ST_HBLANK;
            blank_cnt_d = cfg_q.h_blank - 16'd1;
            y_d         = y_q + 16'd1;
          end else if (cfg_q.v_blank != 16'd0) begin
            state_d     = ST_VBLANK;
            blank_cnt_d = cfg_q.v_blank - 16'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HBLANK, ST_VBLANK: begin
          if (blank_cnt_q != 16'd0) blank_cnt_d = blank_cnt_q - 16'd1;
          else                      state_d     = ST_IDLE;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      cfg_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      blank_cnt_q   <= '0;
      frame_count_q <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      x_q           <= x_d;
      y_q           <= y_d;
      bar_cnt_q     <= bar_cnt_d;
      bar_idx_q     <= bar_idx_d;
      blank_cnt_q   <= blank_cnt_d;
      frame_count_q <= frame_count_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      busy_q        <= busy_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = tuser_q;
  assign frame_count   = frame_count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Self-checking bench for video_pattern_source on a 16x4 frame with 2-pixel
// bars; expected beats come from a coordinate/arithmetic reference model.
module tb_video_pattern_source;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int BW = 2;
  localparam logic [31:0] BAR_TBL [8] = '{32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
                                          32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_mode;
  logic [31:0] solid_color;
  logic [15:0] h_blank_cycles, v_blank_cycles;
  logic [15:0] frame_count;
  logic        busy;

  video_pattern_source_if #(.DATA_WIDTH(32)) axis ();

  always #5 clk = ~clk;

  video_pattern_source #(.DATA_WIDTH(32), .H_RES(H), .V_RES(V), .BAR_W(BW)) dut (
    .aclk          (clk),
    .aresetn       (rst_n),
    .enable        (enable),
    .pattern_mode  (pattern_mode),
    .solid_color   (solid_color),
    .h_blank_cycles(h_blank_cycles),
    .v_blank_cycles(v_blank_cycles),
    .m_axis        (axis),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  int checks;
  int failures;

  // Reference model state: next expected coordinate, frame count and the
  // configuration the bench intends to be in force for the current frame.
  int          mx, my, m_mode, m_h, m_v, exp_gap, gap;
  logic [15:0] mfc;
  logic [31:0] m_solid;
  bit          gap_pending, prev_stall;
  logic [31:0] prev_data;
  logic        prev_last, prev_user;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_pixel(input int x, input int y, input int parity);
    logic [7:0] r;
    case (m_mode)
      0: return m_solid;
      1: begin
        r = 8'((x >> 3) & 255);
        return {8'h00, r, r, r};
      end
      2: return BAR_TBL[x / BW];
      default: return ((((x >> 5) ^ (y >> 5) ^ parity) & 1) != 0) ? 32'h00FFFFFF : 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scenario(input int mode, input logic [31:0] solid, input int h, input int v);
    pattern_mode   = 2'(mode);
    solid_color    = solid;
    h_blank_cycles = 16'(h);
    v_blank_cycles = 16'(v);
    m_mode      = mode;
    m_solid     = solid;
    m_h         = h;
    m_v         = v;
    gap_pending = 1'b0;
    prev_stall  = 1'b0;
    enable      = 1'b1;
    tick();
    check("start_latency_tvalid", 64'(axis.tvalid), 64'd1);
  endtask

  // Runs until n beats are accepted; hooks drop enable / switch the mode
  // input right after the given beat count without touching the model cfg.
  task automatic run_beats(input int n, input int ready_pct, input int drop_en_at,
                           input int mode_sw_at, input int new_mode);
    int got;
    int cyc;
    bit rdy;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 4000) begin
      rdy = (int'($urandom_range(99)) < ready_pct);
      axis.tready = rdy;
      if (axis.tvalid) begin
        if (prev_stall)
          check("hold_stable", {60'd0, axis.tvalid, axis.tlast, axis.tuser, 1'b0, 32'd0} | 64'(axis.tdata),
                {60'd0, 1'b1, prev_last, prev_user, 1'b0, 32'd0} | 64'(prev_data));
        if (gap_pending) begin
          check("blank_gap", 64'(gap), 64'(exp_gap));
          gap_pending = 1'b0;
        end
        if (rdy) begin
          check("pixel", 64'(axis.tdata), 64'(ref_pixel(mx, my, int'(mfc[0]))));
          check("tlast", 64'(axis.tlast), 64'(mx == H - 1));
          check("tuser", 64'(axis.tuser), 64'(mx == 0 && my == 0));
          check("frame_count", 64'(frame_count), 64'(mfc));
          if (mx == H - 1 && my == V - 1) begin
            mfc++;
            mx = 0;
            my = 0;
            exp_gap = m_v;
          end else if (mx == H - 1) begin
            mx = 0;
            my++;
            exp_gap = m_h;
          end else begin
            mx++;
            exp_gap = 0;
          end
          gap_pending = 1'b1;
          gap = 0;
          got++;
          if (got == drop_en_at) enable = 1'b0;
          if (got == mode_sw_at) pattern_mode = 2'(new_mode);
        end
      end else if (gap_pending) begin
        gap++;
      end
      prev_stall = axis.tvalid && !rdy;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      prev_user  = axis.tuser;
      tick();
      cyc++;
    end
    if (got < n) check("beat_timeout", 64'(got), 64'(n));
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    repeat (cycles) tick();
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_tvalid"}, 64'(axis.tvalid), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'(mfc));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_mode = 2'd0;
    solid_color = 32'd0;
    h_blank_cycles = 16'd0;
    v_blank_cycles = 16'd0;
    axis.tready = 1'b0;
    mx = 0; my = 0; mfc = 16'd0; gap = 0; exp_gap = 0;
    gap_pending = 1'b0; prev_stall = 1'b0;
    prev_data = 32'd0; prev_last = 1'b0; prev_user = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata", 64'(axis.tdata), 64'd0);
    check("rst_tlast", 64'(axis.tlast), 64'd0);
    check("rst_tuser", 64'(axis.tuser), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();
    check("idle_without_enable", 64'(axis.tvalid), 64'd0);

    // Colour bars, no blanking, continuous ready.
    start_scenario(2, 32'd0, 0, 0);
    run_beats(64, 100, 64, -1, 0);
    expect_idle("bars", 3);

    // Colour bars with blanking, two frames back to back.
    start_scenario(2, 32'd0, 3, 5);
    run_beats(128, 100, 128, -1, 0);
    expect_idle("blank", 10);

    // Ramp under random backpressure.
    start_scenario(1, 32'd0, 0, 0);
    run_beats(128, 30, 128, -1, 0);
    expect_idle("ramp", 3);

    // Solid colour; enable and mode change mid-frame must not disturb it.
    start_scenario(0, 32'h00123456, 0, 0);
    run_beats(64, 100, 10, 20, 3);
    expect_idle("solid", 4);

    // Checkerboard phase alternates between consecutive frames.
    start_scenario(3, 32'd0, 0, 0);
    run_beats(128, 100, 128, -1, 0);
    expect_idle("checker", 3);

    // Reset mid-line while stalled.
    start_scenario(2, 32'd0, 0, 0);
    run_beats(7, 100, -1, -1, 0);
    axis.tready = 1'b0;
    tick();
    tick();
    check("stall_tvalid", 64'(axis.tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(axis.tvalid), 64'd0);
    check("midrst_tlast", 64'(axis.tlast), 64'd0);
    check("midrst_tuser", 64'(axis.tuser), 64'd0);
    check("midrst_tdata", 64'(axis.tdata), 64'd0);
    check("midrst_frame_count", 64'(frame_count), 64'd0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    mx = 0; my = 0; mfc = 16'd0;
    start_scenario(2, 32'd0, 0, 0);
    run_beats(16, 100, 16, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
